// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter for the register bank write port; REGARB_STATS_EN adds grant/conflict counters
module regbank_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 2,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data,
    input  logic [AW-1:0]        rd_addr1,
    input  logic [AW-1:0]        rd_addr2,
    output logic                 rd_hazard1,
    output logic                 rd_hazard2
`ifdef REGARB_STATS_EN
    ,
    output logic [15:0]          grant_count,
    output logic [15:0]          conflict_count
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand;
    logic          found;
    logic          handshake;

    // Walk the requesters starting just after the last winner, wrapping at NREQ-1.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = (ptr == LAST) ? '0 : ptr + 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
            cand = (cand == LAST) ? '0 : cand + 1'b1;
        end
    end

    assign handshake = found && !reset;

    always_comb begin
        gnt = '0;
        if (handshake) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= LAST;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= handshake;
            if (handshake) begin
                ptr     <= gnt_idx;
                wr_addr <= req_addr[gnt_idx*AW +: AW];
                wr_data <= req_data[gnt_idx*DW +: DW];
            end
        end
    end

    // A read is stale if its register is in the write stage or still being requested.
    always_comb begin
        rd_hazard1 = wr_en && (wr_addr == rd_addr1);
        rd_hazard2 = wr_en && (wr_addr == rd_addr2);
        for (int i = 0; i < NREQ; i++) begin
            rd_hazard1 = rd_hazard1 || (req[i] && (req_addr[i*AW +: AW] == rd_addr1));
            rd_hazard2 = rd_hazard2 || (req[i] && (req_addr[i*AW +: AW] == rd_addr2));
        end
    end

`ifdef REGARB_STATS_EN
    logic conflict;

    assign conflict = ($countones(req) > 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count    <= '0;
            conflict_count <= '0;
        end else begin
            if (handshake && (grant_count != 16'hFFFF)) begin
                grant_count <= grant_count + 16'd1;
            end
            if (conflict && (conflict_count != 16'hFFFF)) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb/tb_regbank_write_arbiter.sv - self-checking bench for regbank_write_arbiter
module tb_regbank_write_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 2;
    localparam int DW   = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     gnt;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [DW-1:0]       wr_data;
    logic [AW-1:0]       rd_addr1 = '0;
    logic [AW-1:0]       rd_addr2 = '0;
    logic                rd_hazard1;
    logic                rd_hazard2;
`ifdef REGARB_STATS_EN
    logic [15:0]         grant_count;
    logic [15:0]         conflict_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regbank_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .gnt        (gnt),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_hazard1 (rd_hazard1),
        .rd_hazard2 (rd_hazard2)
`ifdef REGARB_STATS_EN
        ,
        .grant_count    (grant_count),
        .conflict_count (conflict_count)
`endif
    );

    logic [DW-1:0] bank [4];
    always @(posedge clk) begin
        if (wr_en) bank[wr_addr] <= wr_data;
    end

    typedef struct {
        logic [2:0]  req;
        logic [5:0]  addr;
        logic [23:0] data;
        logic [1:0]  rd1;
        logic [1:0]  rd2;
        logic [2:0]  egnt;
        logic        eh1;
        logic        eh2;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } wr_t;

    vec_t vecs[15];
    wr_t  sb[$];
    wr_t  exp_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [5:0] a, input logic [23:0] d,
                                input logic [1:0] r1, input logic [1:0] r2,
                                input logic [2:0] g, input logic h1, input logic h2);
        vec_t v;
        v.req = r; v.addr = a; v.data = d; v.rd1 = r1; v.rd2 = r2;
        v.egnt = g; v.eh1 = h1; v.eh2 = h2;
        return v;
    endfunction

    initial begin
        // addr packs {a2,a1,a0}, data packs {d2,d1,d0}
        vecs[0]  = mk(3'b111, {2'd3, 2'd1, 2'd0}, 24'h302010, 2'd2, 2'd3, 3'b001, 1'b0, 1'b1);
        vecs[1]  = mk(3'b111, {2'd3, 2'd1, 2'd0}, 24'h302010, 2'd2, 2'd3, 3'b010, 1'b0, 1'b1);
        vecs[2]  = mk(3'b111, {2'd3, 2'd1, 2'd0}, 24'h302010, 2'd2, 2'd3, 3'b100, 1'b0, 1'b1);
        vecs[3]  = mk(3'b111, {2'd3, 2'd1, 2'd0}, 24'h302010, 2'd2, 2'd3, 3'b001, 1'b0, 1'b1);
        vecs[4]  = mk(3'b000, 6'd0, 24'h0, 2'd0, 2'd2, 3'b000, 1'b1, 1'b0);
        vecs[5]  = mk(3'b001, {2'd0, 2'd0, 2'd2}, 24'h0000A5, 2'd1, 2'd2, 3'b001, 1'b0, 1'b1);
        vecs[6]  = mk(3'b000, 6'd0, 24'h0, 2'd2, 2'd0, 3'b000, 1'b1, 1'b0);
        vecs[7]  = mk(3'b000, 6'd0, 24'h0, 2'd2, 2'd0, 3'b000, 1'b0, 1'b0);
        vecs[8]  = mk(3'b100, {2'd3, 2'd0, 2'd0}, 24'h330000, 2'd3, 2'd1, 3'b100, 1'b1, 1'b0);
        vecs[9]  = mk(3'b101, {2'd1, 2'd0, 2'd1}, 24'h220011, 2'd3, 2'd1, 3'b001, 1'b1, 1'b1);
        vecs[10] = mk(3'b100, {2'd1, 2'd0, 2'd1}, 24'h220011, 2'd3, 2'd1, 3'b100, 1'b0, 1'b1);
        vecs[11] = mk(3'b000, 6'd0, 24'h0, 2'd1, 2'd0, 3'b000, 1'b1, 1'b0);
        vecs[12] = mk(3'b010, {2'd0, 2'd3, 2'd0}, 24'h004400, 2'd3, 2'd0, 3'b010, 1'b1, 1'b0);
        vecs[13] = mk(3'b000, 6'd0, 24'h0, 2'd3, 2'd0, 3'b000, 1'b1, 1'b0);
        vecs[14] = mk(3'b000, 6'd0, 24'h0, 2'd3, 2'd0, 3'b000, 1'b0, 1'b0);

        // Reset state, including gnt forced low under reset
        req = 3'b111;
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_wr_en", 32'(wr_en), 32'h0);
        chk("reset_wr_addr", 32'(wr_addr), 32'h0);
        chk("reset_wr_data", 32'(wr_data), 32'h0);
        req = '0;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            req = vecs[i].req; req_addr = vecs[i].addr; req_data = vecs[i].data;
            rd_addr1 = vecs[i].rd1; rd_addr2 = vecs[i].rd2;
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_wr = sb.pop_front();
                chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'h1);
                chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(exp_wr.a));
                chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(exp_wr.d));
            end else begin
                chk($sformatf("v%0d_wr_en_idle", i), 32'(wr_en), 32'h0);
            end
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].egnt));
            chk($sformatf("v%0d_hazard1", i), 32'(rd_hazard1), 32'(vecs[i].eh1));
            chk($sformatf("v%0d_hazard2", i), 32'(rd_hazard2), 32'(vecs[i].eh2));
            for (int k = 0; k < NREQ; k++) begin
                if (vecs[i].egnt[k]) begin
                    exp_wr.a = vecs[i].addr[k*AW +: AW];
                    exp_wr.d = vecs[i].data[k*DW +: DW];
                    sb.push_back(exp_wr);
                end
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("bank0", 32'(bank[0]), 32'h10);
        chk("bank1", 32'(bank[1]), 32'h22);
        chk("bank2", 32'(bank[2]), 32'hA5);
        chk("bank3", 32'(bank[3]), 32'h44);

        // Reset while a write is in the write stage
        @(posedge clk);
        #1;
        req = 3'b001; req_addr = {2'd0, 2'd0, 2'd1}; req_data = 24'h00005A;
        @(posedge clk);
        #1;
        req = 3'b000;
        chk("midrst_wr_en_before", 32'(wr_en), 32'h1);
        req = 3'b110; req_addr = {2'd0, 2'd2, 2'd0}; req_data = 24'h007700;
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(wr_en), 32'h0);
        chk("midrst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'h2);
        @(posedge clk);
        #1;
        req = 3'b000;
        chk("post_rst_wr_en", 32'(wr_en), 32'h1);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'h2);
        chk("post_rst_wr_data", 32'(wr_data), 32'h77);
        @(posedge clk);
        #1;
        chk("post_rst_wr_en_drop", 32'(wr_en), 32'h0);
        chk("lost_write_bank1", 32'(bank[1]), 32'h22);
        chk("post_rst_bank2", 32'(bank[2]), 32'h77);

`ifdef REGARB_STATS_EN
        reset = 1'b1;
        #2;
        chk("stats_rst_grant", 32'(grant_count), 32'h0);
        chk("stats_rst_conflict", 32'(conflict_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        req_addr = {2'd2, 2'd1, 2'd0}; req_data = 24'h030201;
        req = 3'b011;
        @(negedge clk); req = 3'b011;
        @(negedge clk); req = 3'b001;
        @(negedge clk); req = 3'b010;
        @(negedge clk); req = 3'b100;
        @(negedge clk); req = 3'b000;
        @(negedge clk);
        chk("stats_grant_count", 32'(grant_count), 32'd5);
        chk("stats_conflict_count", 32'(conflict_count), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
